// File: rtl/rv_load_pkg.sv
// Shared definitions for the load path: access-size encodings, the load
// extender FSM state type and helpers for classifying a load's first beat.
// No ports (package).
package rv_load_pkg;

    // Access size, log2 of the number of bytes loaded.
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_HI = 1'b1
    } state_e;

    // A doubleword load only exists on a 64-bit datapath.
    function automatic logic size_legal(input logic [1:0] size, input int unsigned xlen);
        return !((size == SZ_D) && (xlen == 32));
    endfunction

    // True when the access runs past the end of the current memory word.
    function automatic logic is_split(input int unsigned offset, input logic [1:0] size,
                                      input int unsigned word_bytes);
        return (offset + (32'd1 << size)) > word_bytes;
    endfunction

endpackage

// File: rtl/load_extend_core.sv
// Combinational byte select / word merge and sign/zero extension.
// Ports:
//   lo_word      in   XLEN  word holding the first byte of the access
//   hi_word      in   XLEN  following word (only matters for split accesses)
//   offset       in   OW    byte offset of the access within lo_word
//   size         in   2     access size (rv_load_pkg::size_e encoding)
//   is_unsigned  in   1     1 = zero-extend, 0 = sign-extend
//   data         out  XLEN  extended result
module load_extend_core
    import rv_load_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    localparam int unsigned OW = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] lo_word,
    input  logic [XLEN-1:0] hi_word,
    input  logic [OW-1:0]   offset,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] data
);

    logic [2*XLEN-1:0] joined;
    logic [OW+2:0]     shamt;
    logic [XLEN-1:0]   sel;
    logic [XLEN-1:0]   ext_w;
    logic              fill_b;
    logic              fill_h;

    // Treating the two words as one little-endian byte stream makes the
    // aligned and split cases the same right shift by offset bytes.
    assign joined = {hi_word, lo_word};
    assign shamt  = {offset, 3'b000};
    assign sel    = XLEN'(joined >> shamt);

    assign fill_b = !is_unsigned && sel[7];
    assign fill_h = !is_unsigned && sel[15];

    generate
        if (XLEN == 32) begin : g_w_full
            assign ext_w = sel;
        end else begin : g_w_ext
            logic fill_w;
            assign fill_w = !is_unsigned && sel[31];
            assign ext_w  = {{(XLEN-32){fill_w}}, sel[31:0]};
        end
    endgenerate

    always_comb begin
        data = sel;
        case (size)
            SZ_B:    data = {{(XLEN-8){fill_b}}, sel[7:0]};
            SZ_H:    data = {{(XLEN-16){fill_h}}, sel[15:0]};
            SZ_W:    data = ext_w;
            default: data = sel;
        endcase
    end

endmodule

// File: rtl/load_extend_unit.sv
// Load extender: picks a byte/half/word/double out of a memory read word
// (merging two consecutive words for split loads when enabled), extends it
// to XLEN and returns it through a registered valid/ready stage.
// Ports:
//   clk          in   1     rising-edge clock
//   rst_n        in   1     asynchronous active-low reset
//   in_valid     in   1     memory word beat valid
//   in_ready     out  1     unit can accept a beat
//   in_data      in   XLEN  aligned memory read word
//   in_offset    in   OW    byte offset in word (first beat only)
//   in_size      in   2     0=byte 1=half 2=word 3=double (first beat only)
//   in_unsigned  in   1     1=zero-extend, 0=sign-extend
//   out_valid    out  1     result valid
//   out_ready    in   1     consumer accepts result
//   out_data     out  XLEN  extended result
//   out_err      out  1     illegal size, or split load with merging disabled
module load_extend_unit
    import rv_load_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter bit          MISALIGN_EN = 1'b1,
    localparam int unsigned OW = $clog2(XLEN / 8)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_data,
    input  logic [OW-1:0]   in_offset,
    input  logic [1:0]      in_size,
    input  logic            in_unsigned,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            out_err
);

    localparam int unsigned WB = XLEN / 8;

    state_e          state;
    logic [XLEN-1:0] stage_lo;
    logic [OW-1:0]   stage_off;
    logic [1:0]      stage_size;
    logic            stage_uns;

    logic            accept;
    logic            first_legal;
    logic            first_split;

    logic [XLEN-1:0] core_lo;
    logic [XLEN-1:0] core_hi;
    logic [OW-1:0]   core_off;
    logic [1:0]      core_size;
    logic            core_uns;
    logic [XLEN-1:0] core_data;

    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;
    assign first_legal = size_legal(in_size, XLEN);
    assign first_split = is_split(32'(in_offset), in_size, WB);

    // In WAIT_HI the staged low beat and its attributes drive the core and the
    // incoming beat becomes the high word; the second beat's offset/size are ignored.
    always_comb begin
        core_lo   = in_data;
        core_hi   = '0;
        core_off  = in_offset;
        core_size = in_size;
        core_uns  = in_unsigned;
        if (state == WAIT_HI) begin
            core_lo   = stage_lo;
            core_hi   = in_data;
            core_off  = stage_off;
            core_size = stage_size;
            core_uns  = stage_uns;
        end
    end

    load_extend_core #(.XLEN(XLEN)) u_core (
        .lo_word     (core_lo),
        .hi_word     (core_hi),
        .offset      (core_off),
        .size        (core_size),
        .is_unsigned (core_uns),
        .data        (core_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            stage_lo   <= '0;
            stage_off  <= '0;
            stage_size <= '0;
            stage_uns  <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_err    <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (!first_legal) begin
                            out_valid <= 1'b1;
                            out_err   <= 1'b1;
                            out_data  <= '0;
                        end else if (!first_split) begin
                            out_valid <= 1'b1;
                            out_err   <= 1'b0;
                            out_data  <= core_data;
                        end else if (!MISALIGN_EN) begin
                            out_valid <= 1'b1;
                            out_err   <= 1'b1;
                            out_data  <= '0;
                        end else begin
                            stage_lo   <= in_data;
                            stage_off  <= in_offset;
                            stage_size <= in_size;
                            stage_uns  <= in_unsigned;
                            state      <= WAIT_HI;
                        end
                    end
                    WAIT_HI: begin
                        out_valid <= 1'b1;
                        out_err   <= 1'b0;
                        out_data  <= core_data;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_load_extend_unit.sv
// Scoreboard bench for load_extend_unit: three instances (32-bit with merging,
// 32-bit without merging, 64-bit with merging) share the stimulus bus; the
// selected instance gets in_valid and expectations are queued per instance.
module tb_load_extend_unit;

    typedef struct {
        logic [63:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld0, vld1, vld2;
    logic        rdy0, rdy1, rdy2;
    logic        ov0, ov1, ov2;
    logic        oe0, oe1, oe2;
    logic [31:0] od0, od1;
    logic [63:0] od2;
    logic [63:0] in_data;
    logic [2:0]  in_off;
    logic [1:0]  in_size;
    logic        in_uns;
    logic        out_ready;

    exp_t q0[$], q1[$], q2[$];
    exp_t e0, e1, e2;
    int   checks = 0;
    int   failures = 0;
    int   pops0 = 0;
    int   base;

    always #5 clk = ~clk;

    load_extend_unit #(.XLEN(32), .MISALIGN_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(vld0), .in_ready(rdy0),
        .in_data(in_data[31:0]), .in_offset(in_off[1:0]), .in_size(in_size),
        .in_unsigned(in_uns), .out_valid(ov0), .out_ready(out_ready),
        .out_data(od0), .out_err(oe0)
    );

    load_extend_unit #(.XLEN(32), .MISALIGN_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(vld1), .in_ready(rdy1),
        .in_data(in_data[31:0]), .in_offset(in_off[1:0]), .in_size(in_size),
        .in_unsigned(in_uns), .out_valid(ov1), .out_ready(out_ready),
        .out_data(od1), .out_err(oe1)
    );

    load_extend_unit #(.XLEN(64), .MISALIGN_EN(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(vld2), .in_ready(rdy2),
        .in_data(in_data), .in_offset(in_off), .in_size(in_size),
        .in_unsigned(in_uns), .out_valid(ov2), .out_ready(out_ready),
        .out_data(od2), .out_err(oe2)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic get_rdy(input int s);
        case (s)
            0:       return rdy0;
            1:       return rdy1;
            default: return rdy2;
        endcase
    endfunction

    task automatic set_vld(input int s, input logic v);
        case (s)
            0:       vld0 = v;
            1:       vld1 = v;
            default: vld2 = v;
        endcase
    endtask

    // Drive one beat to instance s; if push is set, queue the result it must produce.
    task automatic send(input int s, input logic [63:0] d, input logic [2:0] off,
                        input logic [1:0] sz, input logic u, input logic push,
                        input logic [63:0] ed, input logic ee);
        exp_t e;
        int   n;
        e.data  = ed;
        e.err   = ee;
        in_data = d;
        in_off  = off;
        in_size = sz;
        in_uns  = u;
        set_vld(s, 1'b1);
        if (push) begin
            case (s)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
        n = 0;
        while (!get_rdy(s) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) check_eq("in_ready_timeout", 64'(get_rdy(s)), 64'd1);
        @(posedge clk);
        #1;
        set_vld(s, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n && ov0 && out_ready) begin
            if (q0.size() == 0) check_eq("unexpected_out_a", 64'(ov0), 64'd0);
            else begin
                e0 = q0.pop_front();
                check_eq("data_a", {32'd0, od0}, e0.data);
                check_eq("err_a", 64'(oe0), 64'(e0.err));
                pops0++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov1 && out_ready) begin
            if (q1.size() == 0) check_eq("unexpected_out_b", 64'(ov1), 64'd0);
            else begin
                e1 = q1.pop_front();
                check_eq("data_b", {32'd0, od1}, e1.data);
                check_eq("err_b", 64'(oe1), 64'(e1.err));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov2 && out_ready) begin
            if (q2.size() == 0) check_eq("unexpected_out_c", 64'(ov2), 64'd0);
            else begin
                e2 = q2.pop_front();
                check_eq("data_c", od2, e2.data);
                check_eq("err_c", 64'(oe2), 64'(e2.err));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        vld0 = 1'b0; vld1 = 1'b0; vld2 = 1'b0;
        in_data = '0; in_off = '0; in_size = '0; in_uns = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid_a", 64'(ov0), 64'd0);
        check_eq("rst_data_a", {32'd0, od0}, 64'd0);
        check_eq("rst_err_a", 64'(oe0), 64'd0);
        check_eq("rst_valid_b", 64'(ov1), 64'd0);
        check_eq("rst_valid_c", 64'(ov2), 64'd0);
        check_eq("rst_data_c", od2, 64'd0);
        check_eq("rst_in_ready_a", 64'(rdy0), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Byte / half extraction, signed and unsigned.
        send(0, 64'h1234_F6AB, 3'd1, 2'd0, 1'b0, 1'b1, 64'hFFFF_FFF6, 1'b0);
        send(0, 64'h1234_F6AB, 3'd1, 2'd0, 1'b1, 1'b1, 64'h0000_00F6, 1'b0);
        send(0, 64'h8001_0000, 3'd2, 2'd1, 1'b0, 1'b1, 64'hFFFF_8001, 1'b0);
        send(0, 64'h8001_0000, 3'd2, 2'd1, 1'b1, 1'b1, 64'h0000_8001, 1'b0);

        // Split word: nothing comes out until the second beat.
        send(0, 64'hAA00_0000, 3'd3, 2'd2, 1'b0, 1'b0, 64'd0, 1'b0);
        check_eq("split_no_early_valid", 64'(ov0), 64'd0);
        send(0, 64'h0033_2211, 3'd0, 2'd0, 1'b1, 1'b1, 64'h3322_11AA, 1'b0);

        // Split word with merging disabled, and illegal size at XLEN=32.
        send(1, 64'hAA00_0000, 3'd3, 2'd2, 1'b0, 1'b1, 64'd0, 1'b1);
        send(0, 64'hFFFF_FFFF, 3'd0, 2'd3, 1'b0, 1'b1, 64'd0, 1'b1);
        @(posedge clk);
        #1;

        // Backpressure: result held, input blocked.
        out_ready = 1'b0;
        send(0, 64'h0000_0064, 3'd0, 2'd0, 1'b1, 1'b1, 64'h0000_0064, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_in_ready", 64'(rdy0), 64'd0);
            check_eq("stall_valid", 64'(ov0), 64'd1);
            check_eq("stall_data", {32'd0, od0}, 64'h0000_0064);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back aligned loads at one per cycle.
        base = pops0;
        send(0, 64'd100, 3'd0, 2'd0, 1'b1, 1'b1, 64'd100, 1'b0);
        send(0, 64'd250, 3'd0, 2'd0, 1'b1, 1'b1, 64'd250, 1'b0);
        send(0, 64'd69,  3'd0, 2'd0, 1'b1, 1'b1, 64'd69,  1'b0);
        check_eq("throughput_pops", 64'(pops0 - base), 64'd2);
        @(posedge clk);
        #1;

        // 64-bit datapath.
        send(2, 64'h8000_0000_0000_0001, 3'd0, 2'd3, 1'b0, 1'b1, 64'h8000_0000_0000_0001, 1'b0);
        send(2, 64'h8765_4321_0000_0000, 3'd4, 2'd2, 1'b0, 1'b1, 64'hFFFF_FFFF_8765_4321, 1'b0);
        send(2, 64'h8765_4321_0000_0000, 3'd4, 2'd2, 1'b1, 1'b1, 64'h0000_0000_8765_4321, 1'b0);
        send(2, 64'hCDAB_0000_0000_0000, 3'd6, 2'd2, 1'b0, 1'b0, 64'd0, 1'b0);
        send(2, 64'h0000_0000_0000_9412, 3'd0, 2'd0, 1'b1, 1'b1, 64'hFFFF_FFFF_9412_CDAB, 1'b0);
        @(posedge clk);
        #1;

        // Reset drops a pending result immediately.
        out_ready = 1'b0;
        send(0, 64'h55, 3'd0, 2'd0, 1'b1, 1'b0, 64'd0, 1'b0);
        check_eq("pre_reset_valid", 64'(ov0), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_valid", 64'(ov0), 64'd0);
        check_eq("async_reset_data", {32'd0, od0}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset in WAIT_HI discards the staged beat.
        send(0, 64'hBB00_0000, 3'd2, 2'd2, 1'b0, 1'b0, 64'd0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("wait_hi_reset_valid", 64'(ov0), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(0, 64'h0000_807F, 3'd0, 2'd0, 1'b0, 1'b1, 64'h0000_007F, 1'b0);

        for (int i = 0; i < 20 && (q0.size() + q1.size() + q2.size()) != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("drain_a", 64'(q0.size()), 64'd0);
        check_eq("drain_b", 64'(q1.size()), 64'd0);
        check_eq("drain_c", 64'(q2.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
